// File: rtl/leaf_pkt_tx_if.sv
// User-side payload handshake and BFT packet lanes of a leaf transmit port.
// master = user kernel / BFT side, slave = the packetizer.
interface leaf_pkt_tx_if #(
    parameter int PACKET_BITS  = 49,
    parameter int PAYLOAD_BITS = 32
);
    logic [PAYLOAD_BITS-1:0] din_leaf_user2tx;
    logic                    vld_user2tx;
    logic                    ack_tx2user;
    logic [PACKET_BITS-1:0]  din_leaf_bft2tx;
    logic [PACKET_BITS-1:0]  dout_leaf_tx2bft;

    modport master (
        output din_leaf_user2tx,
        output vld_user2tx,
        output din_leaf_bft2tx,
        input  ack_tx2user,
        input  dout_leaf_tx2bft
    );

    modport slave (
        input  din_leaf_user2tx,
        input  vld_user2tx,
        input  din_leaf_bft2tx,
        output ack_tx2user,
        output dout_leaf_tx2bft
    );
endinterface

// File: rtl/leaf_pkt_tx.sv
// User-to-BFT packetizer for one leaf output port: wraps payload words into
// addressed BFT packets under credit-based flow control against the remote BRAM.
module leaf_pkt_tx #(
    parameter int PACKET_BITS   = 49,
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_LEAF_BITS = 5,
    parameter int NUM_PORT_BITS = 4,
    parameter int NUM_ADDR_BITS = 7,
    parameter int SRC_PORT      = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     ap_start,
    input  logic                     resend,
    input  logic [NUM_LEAF_BITS-1:0] cfg_dest_leaf,
    input  logic [NUM_PORT_BITS-1:0] cfg_dest_port,
    leaf_pkt_tx_if.slave             bus,
    output logic [NUM_ADDR_BITS:0]   credits,
    output logic                     err_credit_ovf
);

    localparam int CW       = NUM_ADDR_BITS + 1;
    localparam int PORT_LSB = PAYLOAD_BITS + NUM_ADDR_BITS;
    localparam int SRC_LSB  = PAYLOAD_BITS - NUM_PORT_BITS;
    localparam logic [CW:0]              CREDIT_MAX = {1'b0, 1'b1, {NUM_ADDR_BITS{1'b0}}};
    localparam logic [NUM_PORT_BITS-1:0] SRC_PORT_F = NUM_PORT_BITS'(SRC_PORT);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t                   state;
    logic                     ap_start_q;
    logic [NUM_LEAF_BITS-1:0] dest_leaf;
    logic [NUM_PORT_BITS-1:0] dest_port;
    logic [NUM_ADDR_BITS-1:0] wr_addr;
    logic                     vld_p1;
    logic [PACKET_BITS-2:0]   data_p1;

    logic                     is_ret;
    logic [CW:0]              ret_cnt;
    logic [CW:0]              credit_sum;
    logic                     unused_bft;

    function automatic logic [CW-1:0] sat_credits(input logic [CW:0] sum);
        return (sum > CREDIT_MAX) ? CREDIT_MAX[CW-1:0] : sum[CW-1:0];
    endfunction

    // Credit return decode; only registered state feeds ack, never this path.
    assign is_ret = bus.din_leaf_bft2tx[PACKET_BITS-1]
                 && (bus.din_leaf_bft2tx[PORT_LSB +: NUM_PORT_BITS] == '0)
                 && (bus.din_leaf_bft2tx[SRC_LSB +: NUM_PORT_BITS] == SRC_PORT_F);
    assign ret_cnt    = is_ret ? {1'b0, bus.din_leaf_bft2tx[CW-1:0]} : '0;
    assign credit_sum = {1'b0, credits} + ret_cnt - {{CW{1'b0}}, bus.ack_tx2user};
    assign unused_bft = ^bus.din_leaf_bft2tx;

    assign bus.ack_tx2user = (state == RUN) && bus.vld_user2tx && (credits != '0) && !resend;

    // resend blanks the output lane in the same cycle; the dropped packet keeps its credit/address.
    assign bus.dout_leaf_tx2bft = (vld_p1 && !resend) ? {1'b1, data_p1} : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            ap_start_q     <= 1'b0;
            dest_leaf      <= '0;
            dest_port      <= '0;
            wr_addr        <= '0;
            vld_p1         <= 1'b0;
            credits        <= CREDIT_MAX[CW-1:0];
            err_credit_ovf <= 1'b0;
        end else begin
            ap_start_q <= ap_start;
            case (state)
                IDLE: begin
                    if (ap_start && !ap_start_q) begin
                        state     <= RUN;
                        dest_leaf <= cfg_dest_leaf;
                        dest_port <= cfg_dest_port;
                    end
                end
                RUN: begin
                    if (!ap_start)  state <= IDLE;
                    else if (resend) state <= HOLD;
                end
                HOLD: begin
                    if (!ap_start)   state <= IDLE;
                    else if (!resend) state <= RUN;
                end
                default: state <= IDLE;
            endcase

            vld_p1 <= bus.ack_tx2user;
            if (bus.ack_tx2user) wr_addr <= wr_addr + 1'b1;

            credits <= sat_credits(credit_sum);
            if (credit_sum > CREDIT_MAX) err_credit_ovf <= 1'b1;
        end
    end

    // p1: packet body, qualified by vld_p1
    always_ff @(posedge clk) begin
        if (bus.ack_tx2user)
            data_p1 <= {dest_leaf, dest_port, wr_addr, bus.din_leaf_user2tx};
    end

endmodule

// File: tb/tb_leaf_pkt_tx.sv
// Directed plus randomized bench for leaf_pkt_tx against a cycle-level behavioural model.
module tb_leaf_pkt_tx;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ap_start = 1'b0;
    logic        resend = 1'b0;
    logic [4:0]  cfg_dest_leaf = '0;
    logic [3:0]  cfg_dest_port = '0;
    logic [7:0]  credits;
    logic        err_credit_ovf;

    leaf_pkt_tx_if bus_if ();

    leaf_pkt_tx dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ap_start      (ap_start),
        .resend        (resend),
        .cfg_dest_leaf (cfg_dest_leaf),
        .cfg_dest_port (cfg_dest_port),
        .bus           (bus_if),
        .credits       (credits),
        .err_credit_ovf(err_credit_ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    int          m_credits;
    int          m_addr;
    int          acks;
    bit          m_err, m_run, m_prev_ap, m_paused;
    logic [4:0]  m_leaf;
    logic [3:0]  m_port;
    logic [48:0] m_pend;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [48:0] cred_pkt(input logic [7:0] cnt, input logic [31:0] noise);
        return {1'b1, noise[4:0], 4'h0, noise[11:5], 4'h1, noise[31:12], cnt};
    endfunction

    task automatic model_reset();
        m_credits = 128; m_addr = 0; m_err = 0; m_run = 0;
        m_prev_ap = 0; m_paused = 0; m_leaf = '0; m_port = '0; m_pend = '0;
    endtask

    // One clock: drive at edge+1, check at edge+3, advance model to the next edge.
    task automatic cycle(input bit vld, input logic [31:0] data, input logic [48:0] bft, input bit rs);
        bit exp_ack;
        int ret;
        bus_if.vld_user2tx      = vld;
        bus_if.din_leaf_user2tx = data;
        bus_if.din_leaf_bft2tx  = bft;
        resend                  = rs;
        #2;
        exp_ack = m_run && !m_paused && vld && (m_credits > 0) && !rs;
        check("ack",     64'(bus_if.ack_tx2user),      64'(exp_ack));
        check("dout",    64'(bus_if.dout_leaf_tx2bft), rs ? 64'd0 : 64'(m_pend));
        check("credits", 64'(credits),                 64'(m_credits));
        check("err",     64'(err_credit_ovf),          64'(m_err));
        if (exp_ack) acks++;
        ret = (bft[48] && bft[42:39] == 4'h0 && bft[31:28] == 4'h1) ? int'(bft[7:0]) : 0;
        m_pend = exp_ack ? {1'b1, m_leaf, m_port, 7'(m_addr), data} : 49'd0;
        if (exp_ack) m_addr = (m_addr + 1) % 128;
        m_credits = m_credits + ret - (exp_ack ? 1 : 0);
        if (m_credits > 128) begin
            m_credits = 128;
            m_err = 1;
        end
        if (m_run && !ap_start) m_run = 0;
        else if (!m_run && ap_start && !m_prev_ap) begin
            m_run = 1; m_paused = 0; m_leaf = cfg_dest_leaf; m_port = cfg_dest_port;
        end else if (m_run) m_paused = rs;
        m_prev_ap = ap_start;
        @(posedge clk);
        #1;
    endtask

    task automatic async_reset();
        #1;
        reset_n = 1'b0;
        #1;
        check("rst_dout",    64'(bus_if.dout_leaf_tx2bft), 64'd0);
        check("rst_ack",     64'(bus_if.ack_tx2user),      64'd0);
        check("rst_credits", 64'(credits),                 64'd128);
        check("rst_err",     64'(err_credit_ovf),          64'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        bus_if.vld_user2tx = 1'b0;
        bus_if.din_leaf_user2tx = '0;
        bus_if.din_leaf_bft2tx = '0;
        model_reset();
        acks = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_dout",    64'(bus_if.dout_leaf_tx2bft), 64'd0);
        check("reset_ack",     64'(bus_if.ack_tx2user),      64'd0);
        check("reset_credits", 64'(credits),                 64'd128);
        check("reset_err",     64'(err_credit_ovf),          64'd0);
        reset_n = 1'b1;

        // First word
        cfg_dest_leaf = 5'h0A;
        cfg_dest_port = 4'h3;
        cycle(0, 32'h0, 49'd0, 0);
        ap_start = 1'b1;
        cycle(1, 32'hDEADBEEF, 49'd0, 0);
        cycle(1, 32'hDEADBEEF, 49'd0, 0);
        check("first_pkt",     64'(bus_if.dout_leaf_tx2bft), 64'({1'b1, 5'h0A, 4'h3, 7'd0, 32'hDEADBEEF}));
        check("first_credits", 64'(credits), 64'd127);

        // Drain all credits
        for (int i = 0; i < 130; i++) cycle(1, $urandom, 49'd0, 0);
        check("drain_acks",    64'(acks),    64'd128);
        check("drain_credits", 64'(credits), 64'd0);

        // Return of 4 while stalled; first packet after it wraps to address 0
        cycle(1, $urandom, cred_pkt(8'd4, $urandom), 0);
        cycle(1, $urandom, 49'd0, 0);
        check("wrap_addr", 64'(bus_if.dout_leaf_tx2bft[38:32]), 64'd0);
        for (int i = 0; i < 7; i++) cycle(1, $urandom, 49'd0, 0);
        check("ret4_acks", 64'(acks), 64'd132);

        // Simultaneous send and return at 10 credits
        cycle(0, 32'h0, cred_pkt(8'd10, $urandom), 0);
        cycle(1, $urandom, cred_pkt(8'd1, $urandom), 0);
        check("send_ret_credits", 64'(credits), 64'd10);

        // Non-credit packets, then overflow at 126 + 5
        cycle(0, 32'h0, cred_pkt(8'd116, $urandom), 0);
        cycle(0, 32'h0, {1'b1, 5'h00, 4'h2, 7'h00, 4'h1, 20'h0, 8'd5}, 0);
        cycle(0, 32'h0, {1'b1, 5'h00, 4'h0, 7'h00, 4'h7, 20'h0, 8'd5}, 0);
        check("pre_ovf_credits", 64'(credits), 64'd126);
        cycle(0, 32'h0, cred_pkt(8'd5, $urandom), 0);
        check("ovf_credits", 64'(credits), 64'd128);
        check("ovf_err",     64'(err_credit_ovf), 64'd1);
        for (int i = 0; i < 4; i++) cycle(1, $urandom, 49'd0, 0);
        check("ovf_sticky", 64'(err_credit_ovf), 64'd1);

        // Resend pulse mid-stream
        for (int i = 0; i < 12; i++) cycle(1, $urandom, 49'd0, (i >= 4 && i < 7));

        // Asynchronous reset mid-stream
        async_reset();
        cfg_dest_leaf = 5'($urandom);
        cfg_dest_port = 4'($urandom);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic [48:0] bft;
            int r;
            r = int'($urandom_range(0, 15));
            if (r == 0)      bft = cred_pkt(8'($urandom_range(0, 3)), $urandom);
            else if (r == 1) bft = {17'($urandom), $urandom};
            else             bft = '0;
            ap_start = ($urandom_range(0, 63) != 0);
            cycle(($urandom_range(0, 3) != 0), $urandom, bft, ($urandom_range(0, 15) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/leaf_pkt_tx.md
Name: leaf_pkt_tx

Overview:
- User-to-BFT packetizer for one leaf output port.
- Accepts 32-bit payload words from a user kernel over the vld/ack handshake.
- Wraps each word into a 49-bit BFT packet: valid, destination leaf, destination port, BRAM write address, payload.
- Enforces credit-based flow control against the remote leaf's input BRAM, replenished by control packets returning from the BFT.
- Sits between a user kernel output and the leaf's BFT output mux; it is the transmit-side counterpart of the leaf receive path.

Parameters:
- PACKET_BITS, 49, BFT packet width.
- PAYLOAD_BITS, 32, user payload width.
- NUM_LEAF_BITS, 5, destination leaf field width.
- NUM_PORT_BITS, 4, destination port field width.
- NUM_ADDR_BITS, 7, remote BRAM address width; credit ceiling is 2^NUM_ADDR_BITS = 128.
- SRC_PORT, 1, this block's output port number; matched in credit packets.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous active-low reset.
- ap_start  in  1  level; enables transmission.
- resend  in  1  BFT resend request; pauses output.
- cfg_dest_leaf  in  5  destination leaf; sampled on ap_start rising.
- cfg_dest_port  in  4  destination port; sampled on ap_start rising.
- din_leaf_user2tx  in  32  payload from user.
- vld_user2tx  in  1  payload valid.
- ack_tx2user  out  1  payload accepted this cycle.
- din_leaf_bft2tx  in  49  packets from BFT; carries credit returns.
- dout_leaf_tx2bft  out  49  packet to BFT.
- credits  out  8  current credit count, 0..128.
- err_credit_ovf  out  1  sticky; a credit return exceeded the ceiling.

Behaviour:
- Reset (asynchronous, active-low):
  - state=IDLE, dout_leaf_tx2bft=0, ack_tx2user=0.
  - credits=128, write address=0, err_credit_ovf=0, dest registers=0.
- Packet format:
  - [48] valid.
  - [47:43] dest leaf.
  - [42:39] dest port.
  - [38:32] write address.
  - [31:0] payload.
- FSM states: IDLE, RUN, HOLD.
  - IDLE -> RUN on ap_start rising edge (0->1); capture cfg_dest_leaf/port on that edge.
  - RUN -> HOLD while resend=1.
  - HOLD -> RUN when resend=0 (ap_start still 1).
  - RUN/HOLD -> IDLE when ap_start=0.
  - Write address and credits are preserved across HOLD and IDLE; only reset clears them.
- ack_tx2user is combinational: = (state==RUN) & vld_user2tx & (credits!=0) & !resend.
- Transfer: vld & ack in cycle N -> dout_leaf_tx2bft valid in cycle N+1 (registered, latency 1).
  - Address field = current write address; address then increments mod 128 (127 wraps to 0).
  - At most one packet per cycle.
  - Any cycle without a transfer: dout_leaf_tx2bft = 0 next cycle.
- resend=1: dout_leaf_tx2bft forced to 0 combinationally in the same cycle, and no ack. A packet registered on the cycle resend rises is dropped from output but still consumes its credit and address. The remote receiver's resend protocol recovers it; that is outside this block.
- Credit return: a din_leaf_bft2tx packet is a credit return when all hold:
  - [48]=1.
  - [42:39]=0 (control port).
  - [31:28]=SRC_PORT.
  - Its count is [7:0], range 0..128.
  - Credit returns are accepted in any state.
- Credit arithmetic per cycle: credits_next = credits + ret - sent, with sent ∈ {0,1}.
  - Computed at 9 bits; if the result exceeds 128, clamp to 128 and set err_credit_ovf.
  - Simultaneous send and return are both honoured in the same cycle.
- credits==0: ack held low and vld_user2tx stays pending. A return arriving in cycle N allows ack in cycle N+1. No combinational path from din_leaf_bft2tx to ack.
- Non-credit packets on din_leaf_bft2tx are ignored.
- Asynchronous reset mid-packet clears dout_leaf_tx2bft immediately. No partial packet is ever emitted.

Test Plan:
- Reset, cfg_dest_leaf=5'h0A, cfg_dest_port=4'h3, ap_start 0->1, one word 32'hDEADBEEF -> next cycle dout_leaf_tx2bft={1,5'h0A,4'h3,7'd0,32'hDEADBEEF}; credits=127.
- 130 back-to-back words, no returns -> 128 acks; address field wraps 127->0 on the 129th packet (first word of a later burst); ack=0 once credits=0; no packet emitted while stalled.
- At credits=0, inject return {1,x,4'h0,x,4'h1,...,8'd4} -> ack resumes the following cycle; exactly 4 further packets go out.
- Send and return(1) in the same cycle at credits=10 -> credits stays 10.
- Return of 8'd5 at credits=126 -> credits=128, err_credit_ovf=1 and stays 1.
- resend pulsed for 3 cycles mid-stream -> dout_leaf_tx2bft=0 and ack=0 for those cycles; stream resumes with contiguous addresses. Assert reset_n low mid-stream -> outputs cleared asynchronously, credits=128.
